hazard_ctrl: RTL

Hazard and forwarding controller for the 5-stage pipeline CPU. It drives the 2-bit select lines of the two EX-stage operand forwarding muxes (00 register file, 01 WB result, 10 MEM result, 11 unused/zero). It also generates the stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It keeps its own shadow copy of the destination-register information for the EX, MEM and WB stages, and runs a small FSM that freezes the pipeline while data memory is busy.

---
 rtl/hazard_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX operand forwarding selects,
// load-use / branch / data-memory-wait stall and flush controls. Optional macro: HAZARD_TIMEOUT_EN.
module hazard_ctrl #(
  parameter int REG_AW         = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              ex_branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_mem_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              mem_timeout_o
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mem_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("hazard_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_t r_state;
  mem_state_t w_state_nxt;
  logic       w_mem_stall;
  logic       w_timeout;

  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_regwrite;
  logic              r_ex_memread;

  logic              r_mem_valid;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_regwrite;

  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_regwrite;

  logic       w_load_use;
  logic       w_mem_fwd_ok;
  logic       w_wb_fwd_ok;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stall_front;
  logic       w_stall_back;
  logic       w_flush_id;
  logic       w_flush_ex;

`ifdef HAZARD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wait_cnt;

  assign w_timeout = (r_state == ST_WAIT) && !mem_ready_i && (r_wait_cnt == CNT_LAST);

  // Cycle count of the current memory wait, restarted whenever a new wait begins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_WAIT) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT && !mem_ready_i && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i && !mem_ready_i) begin
          w_mem_stall = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ready_i || w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_mem_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_load_use = r_ex_valid && r_ex_memread && (r_ex_rd != '0) && id_valid_i &&
                      ((r_ex_rd == id_rs1_i) || (r_ex_rd == id_rs2_i));

  // Memory wait dominates everything; a taken branch discards the younger load-use consumer.
  always_comb begin
    w_stall_front = 1'b0;
    w_stall_back  = 1'b0;
    w_flush_id    = 1'b0;
    w_flush_ex    = 1'b0;
    if (w_mem_stall) begin
      w_stall_front = 1'b1;
      w_stall_back  = 1'b1;
    end else if (ex_branch_taken_i) begin
      w_flush_id = 1'b1;
      w_flush_ex = 1'b1;
    end else if (w_load_use) begin
      w_stall_front = 1'b1;
      w_flush_ex    = 1'b1;
    end
  end

  // Bubbles clear their register fields too, so an empty EX slot never matches a producer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
    end else if (!w_mem_stall) begin
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_flush_ex || !id_valid_i) begin
        r_ex_valid    <= 1'b0;
        r_ex_rs1      <= '0;
        r_ex_rs2      <= '0;
        r_ex_rd       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end else begin
        r_ex_valid    <= 1'b1;
        r_ex_rs1      <= id_rs1_i;
        r_ex_rs2      <= id_rs2_i;
        r_ex_rd       <= id_rd_i;
        r_ex_regwrite <= id_regwrite_i;
        r_ex_memread  <= id_memread_i;
      end
    end
  end

  assign w_mem_fwd_ok = r_mem_valid && r_mem_regwrite && (r_mem_rd != '0);
  assign w_wb_fwd_ok  = r_wb_valid && r_wb_regwrite && (r_wb_rd != '0);

  // The younger producer in MEM wins over WB when both wrote the same register.
  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs1)) begin
      w_fwd_a = FWD_MEM;
    end else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs1)) begin
      w_fwd_a = FWD_WB;
    end
    if (w_mem_fwd_ok && (r_mem_rd == r_ex_rs2)) begin
      w_fwd_b = FWD_MEM;
    end else if (w_wb_fwd_ok && (r_wb_rd == r_ex_rs2)) begin
      w_fwd_b = FWD_WB;
    end
  end

  assign fwd_a_o       = rst_i ? FWD_RF : w_fwd_a;
  assign fwd_b_o       = rst_i ? FWD_RF : w_fwd_b;
  assign stall_if_o    = !rst_i && w_stall_front;
  assign stall_id_o    = !rst_i && w_stall_front;
  assign stall_ex_o    = !rst_i && w_stall_back;
  assign stall_mem_o   = !rst_i && w_stall_back;
  assign flush_id_o    = !rst_i && w_flush_id;
  assign flush_ex_o    = !rst_i && w_flush_ex;
  assign mem_timeout_o = !rst_i && w_timeout;

endmodule
